sensor_scanner: RTL and testbench

//  Producer side of the sensor error path: polls NUM_SENSORS sensor channels over one shared

---
 rtl/sensor_scanner_pkg.sv | 19 +
 rtl/sensor_scanner_if.sv | 39 +++
 rtl/sensor_scanner_flex_counter.sv | 38 +++
 rtl/sensor_scanner.sv | 139 +++++++++++++
 tb/tb_sensor_scanner.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_scanner_pkg.sv
// sensor_scanner_pkg
//   Shared definitions for the sensor scanner: FSM state encoding, the number of
//   samples taken per channel and the majority-of-3 glitch filter.
package sensor_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int SAMPLES_PER_CH = 3;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sensor_scanner_if.sv
// sensor_scanner_if
//   Bundles the scanner's control, sense and result signals.
//   enable      scan request level (high = scan continuously)
//   sensor_in   shared sense line, already synchronous to clk
//   sensor_sel  one-hot channel select, zero when idle
//   sensors     last completed scan, bit i = channel i
//   scan_done   one-cycle pulse when sensors is updated
//   busy        high while a scan is in progress
//   modport master: the scanner itself; modport slave: the surrounding system.
interface sensor_scanner_if #(
  parameter int NUM_SENSORS = 4
);

  logic                   enable;
  logic                   sensor_in;
  logic [NUM_SENSORS-1:0] sensor_sel;
  logic [NUM_SENSORS-1:0] sensors;
  logic                   scan_done;
  logic                   busy;

  modport master (
    input  enable,
    input  sensor_in,
    output sensor_sel,
    output sensors,
    output scan_done,
    output busy
  );

  modport slave (
    output enable,
    output sensor_in,
    input  sensor_sel,
    input  sensors,
    input  scan_done,
    input  busy
  );

endinterface

// File: rtl/sensor_scanner_flex_counter.sv
// flex_counter
//   Free-running cycle counter that wraps to zero at a run-time selectable
//   rollover value.
//   clk, n_rst      clock and asynchronous active-low reset
//   clear           synchronous return to zero (wins over counting)
//   count_enable    advance the count this cycle
//   rollover_val    terminal count
//   rollover_flag   high while counting and the count sits at the terminal value
module flex_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      if (count == rollover_val) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign rollover_flag = count_enable && (count == rollover_val);

endmodule

// File: rtl/sensor_scanner.sv
// sensor_scanner
//   Polls NUM_SENSORS channels over one shared sense line. Each channel is
//   selected, allowed to settle for SETTLE_CYCLES, then sampled three times; the
//   majority of the three samples becomes that channel's bit. A complete scan is
//   published on sensors together with a one-cycle scan_done pulse.
//   clk     system clock
//   n_rst   asynchronous active-low reset
//   bus     sensor_scanner_if master modport (enable, sensor_in, sensor_sel,
//           sensors, scan_done, busy)
module sensor_scanner
  import sensor_scanner_pkg::*;
#(
  parameter int NUM_SENSORS   = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  sensor_scanner_if.master    bus
);

  localparam int CHW     = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES_PER_CH) ? SETTLE_CYCLES : SAMPLES_PER_CH;
  localparam int CW      = $clog2(CNT_MAX);

  state_t                 state;
  logic [CHW-1:0]         ch;
  logic [1:0]             hist;
  logic [NUM_SENSORS-1:0] shadow;
  logic [NUM_SENSORS-1:0] shadow_next;
  logic [CW-1:0]          cnt_limit;
  logic                   cnt_wrap;
  logic                   cnt_run;
  logic                   new_bit;
  logic                   last_ch;

  // One counter serves both phases; its terminal value follows the state.
  assign cnt_run   = (state == SETTLE) || (state == SAMPLE);
  assign cnt_limit = (state == SAMPLE) ? CW'(SAMPLES_PER_CH - 1) : CW'(SETTLE_CYCLES - 1);

  flex_counter #(
    .WIDTH(CW)
  ) u_cycle_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (!bus.enable),
    .count_enable  (cnt_run),
    .rollover_val  (cnt_limit),
    .rollover_flag (cnt_wrap)
  );

  // The third sample is taken straight from the line so the filtered bit is
  // ready in the same cycle as the last sample.
  assign new_bit = majority3(hist[1], hist[0], bus.sensor_in);
  assign last_ch = (ch == CHW'(NUM_SENSORS - 1));

  always_comb begin
    shadow_next     = shadow;
    shadow_next[ch] = new_bit;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      ch             <= '0;
      hist           <= '0;
      shadow         <= '0;
      bus.sensor_sel <= '0;
      bus.sensors    <= '0;
      bus.scan_done  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.scan_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.enable) begin
            state          <= SETTLE;
            ch             <= '0;
            bus.sensor_sel <= NUM_SENSORS'(1);
            bus.busy       <= 1'b1;
          end
        end

        SETTLE: begin
          if (!bus.enable) begin
            state          <= IDLE;
            ch             <= '0;
            shadow         <= '0;
            bus.sensor_sel <= '0;
            bus.busy       <= 1'b0;
          end else if (cnt_wrap) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (!bus.enable) begin
            state          <= IDLE;
            ch             <= '0;
            shadow         <= '0;
            bus.sensor_sel <= '0;
            bus.busy       <= 1'b0;
          end else begin
            hist <= {hist[0], bus.sensor_in};
            if (cnt_wrap) begin
              shadow <= shadow_next;
              if (last_ch) begin
                // Publish the whole vector at once, including the bit just filtered.
                state          <= DONE;
                bus.sensors    <= shadow_next;
                bus.scan_done  <= 1'b1;
                bus.sensor_sel <= '0;
              end else begin
                state          <= SETTLE;
                ch             <= ch + 1'b1;
                bus.sensor_sel <= bus.sensor_sel << 1;
              end
            end
          end
        end

        DONE: begin
          if (bus.enable) begin
            state          <= SETTLE;
            ch             <= '0;
            bus.sensor_sel <= NUM_SENSORS'(1);
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_scanner.sv
// tb_sensor_scanner
//   Drives two scanner instances (4 channels / settle 2, and 2 channels /
//   settle 1) and compares every cycle against a timeline model: a scan is a
//   position counter running from 1 to NUM_SENSORS*(SETTLE_CYCLES+3)+1, the
//   channel and sample slot follow arithmetically from the position, and the
//   published bit is "at least two of the three samples were 1".
module tb_sensor_scanner;

  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  sensor_scanner_if #(.NUM_SENSORS(4)) bus0 ();
  sensor_scanner_if #(.NUM_SENSORS(2)) bus1 ();

  sensor_scanner #(
    .NUM_SENSORS   (4),
    .SETTLE_CYCLES (2)
  ) dut0 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus0)
  );

  sensor_scanner #(
    .NUM_SENSORS   (2),
    .SETTLE_CYCLES (1)
  ) dut1 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;

  int         nsv[2] = '{4, 2};
  int         stv[2] = '{2, 1};
  int         pos[2];
  bit         samp[2][4][3];
  logic [3:0] msens[2];

  function automatic int periodOf(input int id);
    return nsv[id] * (stv[id] + 3) + 1;
  endfunction

  function automatic int chOf(input int id);
    if (pos[id] >= 1 && pos[id] < periodOf(id)) return (pos[id] - 1) / (stv[id] + 3);
    return -1;
  endfunction

  function automatic int kOf(input int id);
    return (pos[id] - 1) % (stv[id] + 3) - stv[id];
  endfunction

  function automatic logic [3:0] expSel(input int id);
    int c;
    c = chOf(id);
    if (c < 0) return 4'b0000;
    return 4'(1 << c);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      pos[i]   = 0;
      msens[i] = 4'b0000;
    end
  endtask

  task automatic modelStep(input int id, input bit e, input bit d);
    int p;
    int c;
    int k;
    int sum;
    p = periodOf(id);
    c = chOf(id);
    k = kOf(id);
    if (pos[id] == 0) begin
      if (e) pos[id] = 1;
    end else if (pos[id] == p) begin
      pos[id] = e ? 1 : 0;
    end else if (!e) begin
      pos[id] = 0;
    end else begin
      if (k >= 0) samp[id][c][k] = d;
      pos[id]++;
      if (pos[id] == p) begin
        for (int ci = 0; ci < nsv[id]; ci++) begin
          sum = int'(samp[id][ci][0]) + int'(samp[id][ci][1]) + int'(samp[id][ci][2]);
          msens[id][ci] = (sum >= 2);
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("sel0",     32'(bus0.sensor_sel), 32'(expSel(0)));
    checkOutput("sensors0", 32'(bus0.sensors),    32'(msens[0]));
    checkOutput("done0",    32'(bus0.scan_done),  32'(pos[0] == periodOf(0)));
    checkOutput("busy0",    32'(bus0.busy),       32'(pos[0] != 0));
    checkOutput("sel1",     32'(bus1.sensor_sel), 32'(expSel(1)));
    checkOutput("sensors1", 32'(bus1.sensors),    32'(msens[1]));
    checkOutput("done1",    32'(bus1.scan_done),  32'(pos[1] == periodOf(1)));
    checkOutput("busy1",    32'(bus1.busy),       32'(pos[1] != 0));
  endtask

  task automatic applyStimulus(input bit e0, input bit d0, input bit e1, input bit d1);
    bus0.enable    = e0;
    bus0.sensor_in = d0;
    bus1.enable    = e1;
    bus1.sensor_in = d1;
    @(posedge clk);
    modelStep(0, e0, d0);
    modelStep(1, e1, d1);
    #1;
    checkAll();
  endtask

  task automatic checkResetValues();
    checkOutput("rst_sel0",  32'(bus0.sensor_sel), 32'h0);
    checkOutput("rst_sens0", 32'(bus0.sensors),    32'h0);
    checkOutput("rst_done0", 32'(bus0.scan_done),  32'h0);
    checkOutput("rst_busy0", 32'(bus0.busy),       32'h0);
    checkOutput("rst_sel1",  32'(bus1.sensor_sel), 32'h0);
    checkOutput("rst_busy1", 32'(bus1.busy),       32'h0);
  endtask

  bit patA[3] = '{1'b1, 1'b0, 1'b1};
  bit patB[3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int c;
    int k;
    int lastDone;
    int nDone;
    bit d;

    n_rst          = 1'b0;
    bus0.enable    = 1'b0;
    bus0.sensor_in = 1'b0;
    bus1.enable    = 1'b0;
    bus1.sensor_in = 1'b0;
    modelReset();
    #3;
    checkResetValues();
    @(negedge clk);
    n_rst = 1'b1;

    // Reset: async pulse in cycle 7 of a scan clears outputs without a clock edge.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0);
    checkOutput("pre_rst_busy", 32'(bus0.busy), 32'h1);
    #1 n_rst = 1'b0;
    #1;
    modelReset();
    checkResetValues();
    #1 n_rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Channels 1 and 3 high only while selected.
    for (int i = 0; i < 21; i++) begin
      c = chOf(0);
      applyStimulus(1, (c == 1 || c == 3), 0, 0);
    end
    checkOutput("scan_done_21", 32'(bus0.scan_done), 32'h1);
    checkOutput("sensors_1010", 32'(bus0.sensors),   32'hA);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Glitch filter: ch2 sees 1,0,1 then 0,1,0; ch0 stays high throughout.
    for (int t = 0; t < 42; t++) begin
      c = chOf(0);
      k = kOf(0);
      d = 1'b0;
      if (c == 0) d = 1'b1;
      else if (c == 2 && k >= 0) d = (t < 21) ? patA[k] : patB[k];
      applyStimulus(1, d, 0, 0);
      if (t == 20) checkOutput("glitch_101", 32'(bus0.sensors), 32'h5);
      if (t == 41) checkOutput("glitch_010", 32'(bus0.sensors), 32'h1);
    end
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Abort: enable dropped in cycle 8 of the second scan.
    for (int i = 0; i < 29; i++) begin
      c = chOf(0);
      applyStimulus(1, (c == 3), 0, 0);
    end
    applyStimulus(0, 1, 0, 0);
    checkOutput("abort_busy",    32'(bus0.busy),      32'h0);
    checkOutput("abort_done",    32'(bus0.scan_done), 32'h0);
    checkOutput("abort_sensors", 32'(bus0.sensors),   32'h8);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);

    // Continuous scanning: pulses every 21 cycles, select one-hot or zero.
    lastDone = 0;
    nDone    = 0;
    for (int i = 1; i <= 105; i++) begin
      applyStimulus(1, 1'($urandom_range(0, 1)), 0, 0);
      checkOutput("sel_onehot0", 32'($onehot0(bus0.sensor_sel)), 32'h1);
      if (bus0.scan_done) begin
        nDone++;
        checkOutput("done_spacing", 32'(i - lastDone), 32'd21);
        lastDone = i;
      end
    end
    checkOutput("done_count", 32'(nDone), 32'd5);

    // Random enable/data on both instances.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 7) != 0),  1'($urandom_range(0, 1)));
    end
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Small configuration: period 9, all channels high.
    lastDone = 0;
    nDone    = 0;
    for (int i = 1; i <= 27; i++) begin
      applyStimulus(0, 0, 1, 1);
      if (bus1.scan_done) begin
        nDone++;
        checkOutput("small_spacing", 32'(i - lastDone), 32'd9);
        checkOutput("small_sensors", 32'(bus1.sensors), 32'h3);
        lastDone = i;
      end
    end
    checkOutput("small_count", 32'(nDone), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
